// File: rtl/rv_pkg.sv
// Shared RV32 core definitions: data width, register addressing, x0 index.
package rv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [XLEN-1:0] xlen_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port; address 0 always returns zero.
module regfile_read_port
    import rv_pkg::*;
#(
    parameter int unsigned XLEN     = rv_pkg::XLEN,
    parameter int unsigned NUM_REGS = rv_pkg::NUM_REGS,
    parameter int unsigned ADDR_W   = rv_pkg::REG_ADDR_W
) (
    input  logic [ADDR_W-1:0]                 addr,
    input  logic [NUM_REGS-1:1][XLEN-1:0]     regs,
    output logic [XLEN-1:0]                   data
);

    // Select the addressed register; x0 is not stored, so no entry matches it and the default zero remains.
    always_comb begin
        data = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (addr == ADDR_W'(i)) begin
                data = regs[i];
            end
        end
    end

endmodule

// File: rtl/rv32_register_file.sv
// RV32I integer register file: 31 stored registers (x1..x31), x0 reads zero,
// two combinational read ports and one synchronous write port.
module rv32_register_file
    import rv_pkg::*;
#(
    parameter int unsigned XLEN     = rv_pkg::XLEN,
    parameter int unsigned NUM_REGS = rv_pkg::NUM_REGS,
    parameter int unsigned ADDR_W   = rv_pkg::REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [XLEN-1:0]   rd_data,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data
);

    logic [NUM_REGS-1:1][XLEN-1:0] regs;
    logic [NUM_REGS-1:1]           wr_sel;

    // Write decoder: one-hot select of the destination; rd_addr 0 selects nothing, so x0 writes are dropped.
    always_comb begin
        wr_sel = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            wr_sel[i] = write_enable && (rd_addr == ADDR_W'(i));
        end
    end

    // Storage: cleared asynchronously while rst is low, otherwise the selected register captures rd_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '0;
        end else begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    regs[i] <= rd_data;
                end
            end
        end
    end

    regfile_read_port #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_rs1_port (
        .addr (rs1_addr),
        .regs (regs),
        .data (rs1_data)
    );

    regfile_read_port #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_rs2_port (
        .addr (rs2_addr),
        .regs (regs),
        .data (rs2_data)
    );

endmodule

// File: tb/tb_rv32_register_file.sv
// Self-checking bench for rv32_register_file: directed scenarios plus random traffic
// compared every cycle against an array model of the architectural registers.
module tb_rv32_register_file;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        write_enable = 1'b0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic [4:0]  rd_addr = '0;
    logic [31:0] rd_data = '0;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Architectural state as the ISA sees it: 32 plain words, x0 kept at zero.
    logic [31:0] model [32];

    rv32_register_file #(
        .XLEN     (32),
        .NUM_REGS (32),
        .ADDR_W   (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write_enable (write_enable),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] expect_read(input logic [4:0] a);
        if (!rst || a == 5'd0) return 32'd0;
        return model[a];
    endfunction

    // Model update: a committed write lands at the rising edge.
    always @(posedge clk) begin
        if (rst && write_enable && rd_addr != 5'd0) model[rd_addr] = rd_data;
    end

    // Model reset: everything clears the moment rst falls.
    always @(negedge rst) begin
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end

    // Continuous comparison mid-cycle, when inputs are settled.
    always @(negedge clk) begin
        check("model_rs1", rs1_data, expect_read(rs1_addr));
        check("model_rs2", rs2_data, expect_read(rs2_addr));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'd0;

        // 1: reset held for two edges, then all addresses read zero
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            check("reset_rs1", rs1_data, 32'd0);
            check("reset_rs2", rs2_data, 32'd0);
        end

        // 2: back-to-back writes to x1, x2, x3
        tick();
        rs1_addr = 5'd1;
        rs2_addr = 5'd2;
        write_enable = 1'b1;
        rd_addr = 5'd1;
        rd_data = 32'd5;
        tick();
        check("wr_x1", rs1_data, 32'd5);
        rd_addr = 5'd2;
        rd_data = 32'd19;
        tick();
        check("wr_x2", rs2_data, 32'd19);
        rd_addr = 5'd3;
        rd_data = 32'd13;
        tick();
        write_enable = 1'b0;
        rs1_addr = 5'd3;
        #1;
        check("wr_x3", rs1_data, 32'd13);

        // 3: write to x0 is discarded
        write_enable = 1'b1;
        rd_addr = 5'd0;
        rd_data = 32'hDEADBEEF;
        rs1_addr = 5'd0;
        #1;
        check("x0_before", rs1_data, 32'd0);
        tick();
        check("x0_after", rs1_data, 32'd0);
        write_enable = 1'b0;

        // 4: write_enable low leaves storage alone; dual read of the same register
        rd_addr = 5'd4;
        rd_data = 32'd7;
        tick();
        tick();
        tick();
        rs1_addr = 5'd4;
        #1;
        check("we_low_x4", rs1_data, 32'd0);
        rs1_addr = 5'd2;
        rs2_addr = 5'd2;
        #1;
        check("same_rs1", rs1_data, 32'd19);
        check("same_rs2", rs2_data, 32'd19);

        // 5: read during write shows old value until the edge, new value right after
        write_enable = 1'b1;
        rd_addr = 5'd5;
        rd_data = 32'd1;
        tick();
        rs1_addr = 5'd5;
        rd_data = 32'd9;
        #1;
        check("rdw_before", rs1_data, 32'd1);
        tick();
        check("rdw_after", rs1_data, 32'd9);
        write_enable = 1'b0;

        // Random traffic, checked by the per-cycle compare process
        for (int n = 0; n < 400; n++) begin
            write_enable = ($urandom_range(0, 3) != 0);
            rd_addr  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            rd_data  = $urandom;
            rs1_addr = 5'($urandom_range(0, 31));
            rs2_addr = ($urandom_range(0, 7) == 0) ? rs1_addr : 5'($urandom_range(0, 31));
            tick();
        end

        // 6: fill x1..x31 with nonzero values, then drop rst between edges
        write_enable = 1'b1;
        for (int i = 1; i < 32; i++) begin
            rd_addr = 5'(i);
            rd_data = 32'h1000_0000 + 32'(i);
            tick();
        end
        write_enable = 1'b0;
        rs1_addr = 5'd31;
        rs2_addr = 5'd17;
        #1;
        check("full_x31", rs1_data, 32'h1000_001F);
        check("full_x17", rs2_data, 32'h1000_0011);
        rst = 1'b0;
        #1;
        check("async_clr_x31", rs1_data, 32'd0);
        check("async_clr_x17", rs2_data, 32'd0);
        write_enable = 1'b1;
        rd_addr = 5'd8;
        rd_data = 32'hCAFE_F00D;
        tick();
        tick();
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(i);
            #0.1;
            check("in_reset_rs1", rs1_data, 32'd0);
            check("in_reset_rs2", rs2_data, 32'd0);
        end
        write_enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rs1_addr = 5'd8;
        rs2_addr = 5'd1;
        #1;
        check("no_wr_in_reset", rs1_data, 32'd0);
        check("cleared_x1", rs2_data, 32'd0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
